// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetcher. It issues word-address requests under a credit
// limit, buffers in-order responses in a small FIFO tagged with address+1, and supports
// branch redirects that flush the buffer and drop responses still in flight.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] Instruction_code_o,
  output logic [31:0] PC_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  // Address of the request whose response arrives next (after any dropped ones).
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [OutW-1:0]   outst_q, outst_d;
  logic [OutW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       data_q [FIFO_DEPTH];
  logic [31:0]       pc_q   [FIFO_DEPTH];

  logic credit_ok, req_valid, req_fire, rsp_drop, push, pop;

  // Request gating, response classification and FIFO handshakes.
  always_comb begin
    credit_ok = (32'(outst_q) < MAX_OUTSTANDING) &&
                ((32'(outst_q) + 32'(count_q)) < FIFO_DEPTH);
    req_valid = (state_q == StFetch) && !halt_i && !branch_taken_i && credit_ok;
    req_fire  = req_valid && imem_req_ready_i;
    rsp_drop  = imem_rsp_valid_i && (branch_taken_i || (drop_q != '0));
    push      = imem_rsp_valid_i && !rsp_drop;
    pop       = (count_q != '0) && instr_ready_i && !branch_taken_i;
  end

  // Next-state for counters, pointers and addresses; a redirect overrides everything.
  always_comb begin
    outst_d    = outst_q + OutW'(req_fire) - OutW'(imem_rsp_valid_i);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (branch_taken_i) begin
      fetch_pc_d = branch_target_i;
      rsp_pc_d   = branch_target_i;
      // Every request still unanswered after this cycle belongs to the old stream.
      drop_d     = outst_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd1;
      if (push) rsp_pc_d = rsp_pc_q + 32'd1;
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - OutW'(1);
      count_d  = count_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Control FSM; a redirect while idle or halted leaves the state untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:   if (!branch_taken_i) state_q <= StFetch;
        StFetch:  if (halt_i) state_q <= StHalted;
        StHalted: if (!halt_i && !branch_taken_i) state_q <= StFetch;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Counter, pointer and address registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Instruction buffer storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rsp_data_i;
      pc_q[wr_ptr_q]   <= rsp_pc_q + 32'd1;
    end
  end

  assign imem_req_valid_o   = req_valid;
  assign imem_addr_o        = fetch_pc_q;
  assign instr_valid_o      = (count_q != '0);
  assign Instruction_code_o = data_q[rd_ptr_q];
  assign PC_o               = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a latency-configurable memory model feeds the main instance and a
// scoreboard checks every delivered instruction; a second instance exercises address wrap.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i  = '0;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] Instruction_code_o;
  logic [31:0] PC_o;

  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_addr, w_code, w_pc;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = '0;
  logic        w_acc       = 1'b0;
  logic [31:0] w_acc_addr  = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;
  int acc_cnt  = 0;
  logic [31:0] last_acc_addr = '0;

  typedef struct packed {logic [31:0] code; logic [31:0] pc;} exp_t;
  typedef struct {int due; logic [31:0] addr;} pend_t;
  exp_t  exp_q[$];
  pend_t mem_q[$];
  exp_t  sb_e;

  always #5 clk = ~clk;

  ifetch_unit u_dut (
    .clk                (clk),
    .rst                (rst),
    .halt_i             (halt_i),
    .branch_taken_i     (branch_taken_i),
    .branch_target_i    (branch_target_i),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_addr_o        (imem_addr_o),
    .imem_rsp_valid_i   (imem_rsp_valid_i),
    .imem_rsp_data_i    (imem_rsp_data_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .Instruction_code_o (Instruction_code_o),
    .PC_o               (PC_o)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clk                (clk),
    .rst                (rst),
    .halt_i             (1'b0),
    .branch_taken_i     (1'b0),
    .branch_target_i    (32'h0),
    .imem_req_valid_o   (w_req_valid),
    .imem_req_ready_i   (1'b1),
    .imem_addr_o        (w_addr),
    .imem_rsp_valid_i   (w_rsp_valid),
    .imem_rsp_data_i    (w_rsp_data),
    .instr_valid_o      (w_instr_valid),
    .instr_ready_i      (1'b1),
    .Instruction_code_o (w_code),
    .PC_o               (w_pc)
  );

  // Main memory model: answers each accepted request 'lat' cycles later with addr*4.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_q[0].addr << 2;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
  end

  // Wrap-instance memory: fixed one-cycle latency.
  always @(negedge clk) begin
    w_acc      = rst && w_req_valid;
    w_acc_addr = w_addr;
  end
  always @(posedge clk) begin
    #1;
    w_rsp_valid = rst && w_acc;
    w_rsp_data  = w_acc_addr << 2;
  end

  // Monitor: record accepted requests, compare every consumed instruction.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (branch_taken_i) begin
        exp_q.delete();
      end else if (instr_valid_o && instr_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got code %h pc %h, required no instruction",
                   Instruction_code_o, PC_o);
        end else begin
          sb_e = exp_q.pop_front();
          if (Instruction_code_o !== sb_e.code || PC_o !== sb_e.pc) begin
            n_fail++;
            $display("FAIL sb_head: got code %h pc %h, required code %h pc %h",
                     Instruction_code_o, PC_o, sb_e.code, sb_e.pc);
          end
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        mem_q.push_back('{due: cyc + lat, addr: imem_addr_o});
        exp_q.push_back('{code: imem_addr_o << 2, pc: imem_addr_o + 32'd1});
        acc_cnt++;
        last_acc_addr = imem_addr_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    step();
    rst = 1'b0; halt_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    instr_ready_i = 1'b1; imem_req_ready_i = 1'b1; lat = l;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0; halt_i = 1'b0; branch_taken_i = 1'b0;
    instr_ready_i = 1'b1; imem_req_ready_i = 1'b1;
    repeat (2) step();
    samp();
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid_o);
    end
    n_checks++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid_o);
    end
    n_checks++;
    if (imem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h, required 00000000", imem_addr_o);
    end
    n_checks++;
    if (Instruction_code_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_code: got %h, required 00000000", Instruction_code_o);
    end
    n_checks++;
    if (PC_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h, required 00000000", PC_o);
    end
  endtask

  task automatic test_startup();
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      samp();
      n_checks++;
      if (imem_req_valid_o !== (k >= 1)) begin
        n_fail++;
        $display("FAIL startup_req_valid c%0d: got %b, required %b", k, imem_req_valid_o, k >= 1);
      end
      if (k >= 1) begin
        n_checks++;
        if (imem_addr_o !== 32'(k - 1)) begin
          n_fail++;
          $display("FAIL startup_addr c%0d: got %h, required %h", k, imem_addr_o, 32'(k - 1));
        end
      end
      n_checks++;
      if (instr_valid_o !== (k >= 3)) begin
        n_fail++;
        $display("FAIL startup_instr_valid c%0d: got %b, required %b", k, instr_valid_o, k >= 3);
      end
      if (k >= 3) begin
        n_checks++;
        if (Instruction_code_o !== 32'((k - 3) * 4) || PC_o !== 32'(k - 2)) begin
          n_fail++;
          $display("FAIL startup_head c%0d: got code %h pc %h, required code %h pc %h", k,
                   Instruction_code_o, PC_o, 32'((k - 3) * 4), 32'(k - 2));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    base = 32'hFFFF_FFFE;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      samp();
      if (k >= 1) begin
        n_checks++;
        if (w_req_valid !== 1'b1 || w_addr !== base + 32'(k - 1)) begin
          n_fail++;
          $display("FAIL wrap_addr c%0d: got valid %b addr %h, required valid 1 addr %h", k,
                   w_req_valid, w_addr, base + 32'(k - 1));
        end
      end
      if (k >= 3) begin
        n_checks++;
        if (w_instr_valid !== 1'b1 || w_pc !== base + 32'(k - 2) ||
            w_code !== ((base + 32'(k - 3)) << 2)) begin
          n_fail++;
          $display("FAIL wrap_head c%0d: got valid %b code %h pc %h, required valid 1 code %h pc %h",
                   k, w_instr_valid, w_code, w_pc, (base + 32'(k - 3)) << 2, base + 32'(k - 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit seen;
    do_reset(1);
    instr_ready_i = 1'b0;
    base = acc_cnt;
    repeat (12) step();
    samp();
    n_checks++;
    if (acc_cnt - base != 4) begin
      n_fail++; $display("FAIL bp_req_count: got %0d, required 4", acc_cnt - base);
    end
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_valid: got %b, required 0", imem_req_valid_o);
    end
    n_checks++;
    if (instr_valid_o !== 1'b1 || Instruction_code_o !== 32'h0 || PC_o !== 32'h1) begin
      n_fail++;
      $display("FAIL bp_head_hold: got valid %b code %h pc %h, required valid 1 code 0 pc 1",
               instr_valid_o, Instruction_code_o, PC_o);
    end
    step();
    instr_ready_i = 1'b1;
    base = acc_cnt;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      samp();
      if (acc_cnt != base) seen = 1'b1;
    end
    n_checks++;
    if (!seen || last_acc_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_resume_addr: got seen %b addr %h, required seen 1 addr 00000004",
               seen, last_acc_addr);
    end
    repeat (10) step();
  endtask

  task automatic test_redirect();
    bit found;
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_q.size() == 2 && !imem_rsp_valid_i) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL redir_setup: got no 2-outstanding cycle, required one");
    end
    branch_taken_i = 1'b1;
    branch_target_i = 32'h100;
    samp();
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_req_valid: got %b, required 0", imem_req_valid_o);
    end
    step();
    branch_taken_i = 1'b0;
    samp();
    n_checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_after: got valid %b addr %h, required valid 0 addr 00000100",
               instr_valid_o, imem_addr_o);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      samp();
      if (instr_valid_o) found = 1'b1;
    end
    n_checks++;
    if (!found || PC_o !== 32'h101 || Instruction_code_o !== 32'h400) begin
      n_fail++;
      $display("FAIL redir_first: got valid %b code %h pc %h, required valid 1 code 400 pc 101",
               found, Instruction_code_o, PC_o);
    end
    repeat (15) step();
  endtask

  task automatic test_halt();
    int base;
    logic [31:0] a0;
    bit seen;
    do_reset(3);
    repeat (6) step();
    halt_i = 1'b1;
    samp();
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_req_valid: got %b, required 0", imem_req_valid_o);
    end
    base = acc_cnt;
    a0 = last_acc_addr;
    repeat (10) step();
    samp();
    n_checks++;
    if (acc_cnt != base) begin
      n_fail++; $display("FAIL halt_no_new_req: got %0d new, required 0", acc_cnt - base);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL halt_drained: got %0d pending, required 0", exp_q.size());
    end
    step();
    halt_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      samp();
      if (acc_cnt != base) seen = 1'b1;
    end
    n_checks++;
    if (!seen || last_acc_addr !== a0 + 32'd1) begin
      n_fail++;
      $display("FAIL halt_resume_addr: got seen %b addr %h, required seen 1 addr %h",
               seen, last_acc_addr, a0 + 32'd1);
    end
    repeat (10) step();
  endtask

  task automatic test_collision();
    bit found;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_rsp_valid_i && instr_valid_o && instr_ready_i) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL coll_setup: got no rsp+pop cycle, required one");
    end
    branch_taken_i = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_taken_i = 1'b0;
    samp();
    n_checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL coll_after: got valid %b addr %h, required valid 0 addr 00000200",
               instr_valid_o, imem_addr_o);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      samp();
      if (instr_valid_o) found = 1'b1;
    end
    n_checks++;
    if (!found || PC_o !== 32'h201 || Instruction_code_o !== 32'h800) begin
      n_fail++;
      $display("FAIL coll_first: got valid %b code %h pc %h, required valid 1 code 800 pc 201",
               found, Instruction_code_o, PC_o);
    end
    step();
    halt_i = 1'b1;
    repeat (10) step();
    samp();
    n_checks++;
    if (exp_q.size() != 0 || instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d pending valid %b, required 0 pending valid 0",
               exp_q.size(), instr_valid_o);
    end
    halt_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    halt_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = '0;
    imem_req_ready_i = 1'b1;
    instr_ready_i = 1'b1;
    test_reset();
    test_startup();
    test_wrap();
    test_backpressure();
    test_reset();
    test_redirect();
    test_halt();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word address of the first fetch after reset.
REQ-002 Parameter: FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2).
REQ-003 Parameter: MAX_OUTSTANDING, 2, maximum imem requests accepted but not yet answered.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset: sampled on rising clk, asserted when 0.
REQ-006 halt_i  input  1  when 1, no new imem requests are issued.
REQ-007 branch_taken_i  input  1  redirect strobe from the ALU.
REQ-008 branch_target_i  input  32  redirect word address, valid when branch_taken_i=1.
REQ-009 imem_req_valid_o  output  1  fetch request valid.
REQ-010 imem_req_ready_i  input  1  memory accepts request when valid and ready are both 1.
REQ-011 imem_addr_o  output  32  word address of the request.
REQ-012 imem_rsp_valid_i  input  1  response beat; responses return in request order, always accepted.
REQ-013 imem_rsp_data_i  input  32  instruction word of the response.
REQ-014 instr_valid_o  output  1  buffer head holds an instruction.
REQ-015 instr_ready_i  input  1  consumer takes head when valid and ready are both 1.
REQ-016 Instruction_code_o  output  32  head instruction word.
REQ-017 PC_o  output  32  head instruction address plus 1 (wraps mod 2^32), fed to the ALU PC input.

Function
REQ-018 FSM states: IDLE, FETCH, HALTED; reset enters IDLE; IDLE->FETCH next cycle; FETCH->HALTED when halt_i=1; HALTED->FETCH when halt_i=0.
REQ-019 imem_req_valid_o=1 only in FETCH, halt_i=0, branch_taken_i=0, outstanding<MAX_OUTSTANDING, and outstanding+fifo_count<FIFO_DEPTH.
REQ-020 imem_addr_o equals fetch_pc; fetch_pc increments by 1 (wrapping 32'hFFFF_FFFF->0) on each accepted request.
REQ-021 Outstanding counter: +1 on accepted request, -1 on each response, both in one cycle -> unchanged.
REQ-022 Response with drop_cnt=0 is written to the FIFO with address+1 of its request; FIFO never overflows, per the REQ-019 credit rule.
REQ-023 Response with drop_cnt>0 is discarded and drop_cnt decrements by 1.
REQ-024 Redirect (branch_taken_i=1) has priority over all else: FIFO flushed (count=0), fetch_pc<=branch_target_i, drop_cnt<=outstanding after this cycle's accounting, no request issued, any response that cycle discarded.
REQ-025 Redirect in HALTED or IDLE updates fetch_pc and flushes; the state is unchanged.
REQ-026 Pop on instr_valid_o&&instr_ready_i; simultaneous push and pop keeps count; push into empty FIFO visible on instr_valid_o next cycle (1-cycle response-to-output latency).
REQ-027 Outputs Instruction_code_o and PC_o are registered FIFO-head values; hold stable while instr_valid_o=1 and not popped.
REQ-028 Best case throughput: one instruction per cycle with imem_req_ready_i=1 and one-cycle response latency.

Reset
REQ-029 While rst=0: state=IDLE, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
REQ-030 Reset outputs: imem_req_valid_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, Instruction_code_o=0, PC_o=0.
REQ-031 Reset mid-operation discards in-flight responses; the memory is reset together with this block.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory returning addr*4 -> requests 0,1,2..., instr_valid_o from cycle 3, words 0,4,8 with PC_o 1,2,3.
REQ-033 instr_ready_i=0 held -> exactly FIFO_DEPTH=4 requests issued, then imem_req_valid_o=0; raising ready resumes fetch at address 4.
REQ-034 Redirect to 32'h100 with 2 outstanding -> FIFO empty next cycle, both stale responses dropped, first delivered instruction has PC_o=32'h101.
REQ-035 RESET_PC=32'hFFFF_FFFE -> addresses FFFF_FFFE, FFFF_FFFF, 0000_0000; PC_o FFFF_FFFF, 0000_0000, 0000_0001.
REQ-036 halt_i=1 during fetch -> no new requests; outstanding responses still buffered; halt_i=0 resumes from the next sequential address.
REQ-037 Redirect and a response in the same cycle, plus a pop in that cycle -> response dropped, FIFO count 0, fetch_pc=target.
